// File: rtl/brownout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : brownout_pkg
//  Description : State encoding and default constants for the brownout
//                responder. The debug state bus decodes identically wherever
//                this package is imported.
//  Revision    : 1.0  initial release
// ============================================================================
package brownout_pkg;

    // Debug encoding of the responder FSM
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_SAVE    = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam int C_CONFIRM_CNT_DEF  = 3;
    localparam int C_SAVE_TIMEOUT_DEF = 64;
    localparam int C_HOLDOFF_DEF      = 16;
    localparam int C_EVT_W_DEF        = 8;

    // Internal counter widths; each counter is bounded by its FSM exit
    localparam int C_CONFIRM_W = 4;
    localparam int C_TMO_W     = 8;
    localparam int C_QUIET_W   = 8;

endpackage
`default_nettype wire

// File: rtl/brownout_responder_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear. An increment
//                on the same edge as a clear leaves the count at one.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count up to all-ones and stay there; clear restarts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc) begin
            if (clr) begin
                r_count <= WIDTH'(1);
            end else if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end else if (clr) begin
            r_count <= '0;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/brownout_responder.sv
`default_nettype none
// ============================================================================
//  Module      : brownout_responder
//  Description : Qualifies the rate-based brownout flag, runs a save
//                handshake with the retention logic, holds the system safe
//                until the supply has been quiet for HOLDOFF cycles, and
//                keeps an event count plus a sticky save-failure flag.
//  Revision    : 1.0  initial release
// ============================================================================
module brownout_responder
    import brownout_pkg::*;
#(
    parameter int CONFIRM_CNT  = C_CONFIRM_CNT_DEF,
    parameter int SAVE_TIMEOUT = C_SAVE_TIMEOUT_DEF,
    parameter int HOLDOFF      = C_HOLDOFF_DEF,
    parameter int EVT_W        = C_EVT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             brownout,
    input  logic             save_ack,
    input  logic             evt_clr,
    output logic             save_req,
    output logic             sys_hold,
    output logic             irq,
    output logic [EVT_W-1:0] event_cnt,
    output logic             save_fail,
    output logic [1:0]       state
);

    localparam logic [C_CONFIRM_W-1:0] C_CONFIRM  = C_CONFIRM_W'(CONFIRM_CNT);
    localparam logic [C_TMO_W-1:0]     C_TMO_LAST = C_TMO_W'(SAVE_TIMEOUT - 1);
    localparam logic [C_QUIET_W-1:0]   C_HOLDOFF  = C_QUIET_W'(HOLDOFF);

    state_t                  r_state;
    logic [C_CONFIRM_W-1:0]  r_confirm_cnt;
    logic [C_TMO_W-1:0]      r_tmo_cnt;
    logic [C_QUIET_W-1:0]    r_quiet_cnt;
    logic                    r_save_req;
    logic                    r_sys_hold;
    logic                    r_irq;
    logic                    r_save_fail;

    logic                    w_evt_entry;
    logic                    w_tmo_fail;

    // Qualified event (SAVE entry) and unacknowledged save timeout this edge
    always_comb begin
        w_evt_entry = 1'b0;
        w_tmo_fail  = 1'b0;
        if (brownout) begin
            if (r_state == ST_IDLE && CONFIRM_CNT == 1) begin
                w_evt_entry = 1'b1;
            end
            if (r_state == ST_CONFIRM && (r_confirm_cnt + 4'd1) == C_CONFIRM) begin
                w_evt_entry = 1'b1;
            end
        end
        if (r_state == ST_SAVE && !save_ack && r_tmo_cnt == C_TMO_LAST) begin
            w_tmo_fail = 1'b1;
        end
    end

    // Responder FSM with its confirm, timeout and quiet timers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_confirm_cnt <= '0;
            r_tmo_cnt     <= '0;
            r_quiet_cnt   <= '0;
            r_save_req    <= 1'b0;
            r_sys_hold    <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_evt_entry) begin
                r_state       <= ST_SAVE;
                r_confirm_cnt <= '0;
                r_tmo_cnt     <= '0;
                r_save_req    <= 1'b1;
                r_sys_hold    <= 1'b1;
                r_irq         <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (brownout) begin
                            r_state       <= ST_CONFIRM;
                            r_confirm_cnt <= 4'd1;
                        end
                    end
                    ST_CONFIRM: begin
                        if (brownout) begin
                            r_confirm_cnt <= r_confirm_cnt + 4'd1;
                        end else begin
                            r_state       <= ST_IDLE;
                            r_confirm_cnt <= '0;
                        end
                    end
                    ST_SAVE: begin
                        // Ack takes priority over the timeout on the same edge
                        if (save_ack || r_tmo_cnt == C_TMO_LAST) begin
                            r_state     <= ST_HOLD;
                            r_save_req  <= 1'b0;
                            r_quiet_cnt <= C_HOLDOFF;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        end
                    end
                    ST_HOLD: begin
                        if (brownout) begin
                            r_quiet_cnt <= C_HOLDOFF;
                        end else if (r_quiet_cnt == 8'd1) begin
                            r_state     <= ST_IDLE;
                            r_sys_hold  <= 1'b0;
                            r_quiet_cnt <= '0;
                        end else begin
                            r_quiet_cnt <= r_quiet_cnt - 8'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky save-failure flag; a timeout on the clear edge still sets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_save_fail <= 1'b0;
        end else if (w_tmo_fail) begin
            r_save_fail <= 1'b1;
        end else if (evt_clr) begin
            r_save_fail <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (EVT_W)
    ) u_evt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (evt_clr),
        .inc   (w_evt_entry),
        .count (event_cnt)
    );

    assign save_req  = r_save_req;
    assign sys_hold  = r_sys_hold;
    assign irq       = r_irq;
    assign save_fail = r_save_fail;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_brownout_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brownout_responder
//  Description : Self-checking bench for brownout_responder against a
//                cycle-count reference model of the responder behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_brownout_responder;

    localparam int CONFIRM = 3;
    localparam int TMO     = 64;
    localparam int HOLD    = 16;
    localparam int EW      = 2;
    localparam int CMAX    = (1 << EW) - 1;

    logic          clk;
    logic          rst_n;
    logic          brownout;
    logic          save_ack;
    logic          evt_clr;
    logic          save_req;
    logic          sys_hold;
    logic          irq;
    logic [EW-1:0] event_cnt;
    logic          save_fail;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = idle/confirming, 2 = saving, 3 = holding
    int m_phase, m_run, m_age, m_quiet, m_cnt, m_fail, m_irq;

    brownout_responder #(
        .CONFIRM_CNT  (CONFIRM),
        .SAVE_TIMEOUT (TMO),
        .HOLDOFF      (HOLD),
        .EVT_W        (EW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .brownout  (brownout),
        .save_ack  (save_ack),
        .evt_clr   (evt_clr),
        .save_req  (save_req),
        .sys_hold  (sys_hold),
        .irq       (irq),
        .event_cnt (event_cnt),
        .save_fail (save_fail),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic m_reset();
        m_phase = 0; m_run = 0; m_age = 0; m_quiet = 0;
        m_cnt = 0; m_fail = 0; m_irq = 0;
    endtask

    // One clock edge of the reference behaviour, from sampled inputs
    task automatic m_step(input bit b, input bit a, input bit c);
        int inc;
        int fset;
        inc = 0; fset = 0; m_irq = 0;
        case (m_phase)
            0: begin
                if (b) begin
                    m_run++;
                    if (m_run == CONFIRM) begin
                        m_phase = 2; m_age = 0; m_run = 0; m_irq = 1; inc = 1;
                    end
                end else begin
                    m_run = 0;
                end
            end
            2: begin
                m_age++;
                if (a) begin
                    m_phase = 3; m_quiet = 0;
                end else if (m_age == TMO) begin
                    m_phase = 3; m_quiet = 0; fset = 1;
                end
            end
            default: begin
                if (b) m_quiet = 0;
                else m_quiet++;
                if (m_quiet == HOLD) m_phase = 0;
            end
        endcase
        if (inc != 0) m_cnt = c ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
        else if (c) m_cnt = 0;
        if (fset != 0) m_fail = 1;
        else if (c) m_fail = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_all();
        int es;
        es = (m_phase == 0) ? ((m_run > 0) ? 1 : 0) : m_phase;
        chk("state",     {6'd0, state},     8'(es));
        chk("save_req",  {7'd0, save_req},  8'(m_phase == 2));
        chk("sys_hold",  {7'd0, sys_hold},  8'(m_phase != 0));
        chk("irq",       {7'd0, irq},       8'(m_irq));
        chk("event_cnt", {6'd0, event_cnt}, 8'(m_cnt));
        chk("save_fail", {7'd0, save_fail}, 8'(m_fail));
    endtask

    // Apply inputs, advance one edge in DUT and model, compare after the edge
    task automatic tick(input bit b, input bit a, input bit c);
        brownout = b; save_ack = a; evt_clr = c;
        @(posedge clk);
        m_step(b, a, c);
        #1;
        chk_all();
    endtask

    // Qualified event, ack after ack_after cycles in SAVE, then a clean holdoff
    task automatic run_event(input int ack_after, input bit clr_on_entry);
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, clr_on_entry);
        for (int i = 0; i < ack_after; i++) tick(0, 0, 0);
        tick(0, 1, 0);
        for (int i = 0; i < HOLD; i++) tick(0, 0, 0);
    endtask

    initial begin
        int hi;
        brownout = 0; save_ack = 0; evt_clr = 0;
        rst_n = 0;
        m_reset();
        #2;
        chk_all();
        #10 rst_n = 1;
        tick(0, 0, 0);

        // Glitch rejection: two high samples then low
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);

        // Qualified event with ack; measure save_req width
        hi = 0;
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        if (save_req) hi++;
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0);
            if (save_req) hi++;
        end
        tick(0, 1, 0);
        if (save_req) hi++;
        chk("save_req_width", 8'(hi), 8'd6);
        for (int i = 0; i < HOLD; i++) tick(0, 0, 0);
        tick(0, 0, 0);

        // Timeout without ack, then clear
        hi = 0;
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        if (save_req) hi++;
        for (int i = 0; i < TMO; i++) begin
            tick(0, 0, 0);
            if (save_req) hi++;
        end
        chk("tmo_width", 8'(hi), 8'(TMO));
        chk("tmo_fail", {7'd0, save_fail}, 8'd1);
        for (int i = 0; i < HOLD; i++) tick(0, 0, 0);
        tick(0, 0, 1);
        tick(0, 0, 0);

        // Holdoff restart by brownout pulses while holding
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 13; i++) tick(0, 0, 0);
        tick(1, 0, 0);
        for (int i = 0; i < HOLD - 1; i++) tick(0, 0, 0);
        chk("hold_before_release", {7'd0, sys_hold}, 8'd1);
        tick(0, 0, 0);
        chk("released", {7'd0, sys_hold}, 8'd0);

        // Saturation, then clear racing with the fifth event's entry
        for (int k = 0; k < 4; k++) run_event(1, 0);
        chk("saturated", {6'd0, event_cnt}, 8'(CMAX));
        run_event(2, 1);
        chk("clr_race", {6'd0, event_cnt}, 8'd1);

        // Asynchronous reset while saving
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        #3 rst_n = 0;
        m_reset();
        #1;
        chk_all();
        #2 rst_n = 1;
        tick(0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
